regfile_write_port: RTL and testbench

Write side of the processor register file: a 32-entry x WIDTH storage array with a 5-to-32 write decoder, a one-deep write-staging register, and a sequential clear engine. It holds the values that the read-port 32:1 selectors consume through `regs_flat`. It also exposes the staged (not yet committed) write so that the read logic can bypass it. Register 0 is hardwired to zero.

---
 rtl/regfile_write_port.sv | 131 +++++++++++++
 tb/tb_regfile_write_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// Write side of the register file: 32 x WIDTH storage, one-deep write staging register
// for read-port bypass, and a sequential clear engine. Register 0 always reads as zero.
module regfile_write_port #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [32*WIDTH-1:0]   regs_flat,
  output logic                  pend_valid,
  output logic [4:0]            pend_addr,
  output logic [WIDTH-1:0]      pend_data
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic             pend_valid_q, pend_valid_d;
  logic [4:0]       pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [WIDTH-1:0] storage_q [32];

  logic             accept;
  logic [31:0]      wr_en;
  logic [31:0]      clr_en;

  assign wr_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign accept   = wr_valid && wr_ready;

  // Control and staging next state
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept && (wr_addr != 5'd0)) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = wr_addr;
          pend_data_d  = wr_data;
        end
        if (clear_req) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        idx_d   = 5'd1;
        state_d = StClear;
      end
      StClear: begin
        if (idx_q == 5'd31) begin
          idx_d   = 5'd0;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: begin
        idx_d   = 5'd0;
        state_d = StIdle;
      end
    endcase
  end

  // One-hot enables: commit of the staged write, and the clear engine's zeroing slot
  always_comb begin
    wr_en  = '0;
    clr_en = '0;
    if (pend_valid_q) begin
      wr_en[pend_addr_q] = 1'b1;
    end
    if (state_q == StClear) begin
      clr_en[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= 5'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 5'd0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Entry 0 is held at zero so the flat bus carries a constant zero register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (i == 0) begin
          storage_q[i] <= '0;
        end else if (clr_en[i]) begin
          storage_q[i] <= '0;
        end else if (wr_en[i]) begin
          storage_q[i] <= pend_data_q;
        end
      end
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = storage_q[g];
  end

  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;
  assign pend_data  = pend_data_q;

endmodule

// File: tb/tb_regfile_write_port.sv
// Randomized bench for regfile_write_port, compared each cycle against a behavioural model
// of registers, staged write and clear progress.
module tb_regfile_write_port;

  logic              clock;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              clear_req;
  logic              busy;
  logic [32*32-1:0]  regs_flat;
  logic              pend_valid;
  logic [4:0]        pend_addr;
  logic [31:0]       pend_data;

  regfile_write_port #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clear_req  (clear_req),
    .busy       (busy),
    .regs_flat  (regs_flat),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles;

  // Model: register contents, staged write, and clear progress
  // (m_cnt: 0 idle, 1 drain cycle, k in 2..32 means the next edge zeroes register k-1).
  logic [31:0] m_regs [32];
  logic        m_pv;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pv  = 1'b0;
    m_pa  = 5'd0;
    m_pd  = 32'd0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic v, input logic [4:0] a, input logic [31:0] d,
                            input logic c);
    if (m_pv) m_regs[m_pa] = m_pd;
    if (m_cnt == 0) begin
      m_pv = 1'b0;
      if (v && a != 5'd0) begin
        m_pv = 1'b1;
        m_pa = a;
        m_pd = d;
      end
      if (c) m_cnt = 1;
    end else if (m_cnt == 1) begin
      m_pv  = 1'b0;
      m_cnt = 2;
    end else begin
      m_regs[m_cnt-1] = 32'd0;
      m_cnt = (m_cnt == 32) ? 0 : m_cnt + 1;
    end
  endtask

  task automatic check_all();
    check_eq("wr_ready", wr_ready, (m_cnt == 0));
    check_eq("busy", busy, (m_cnt != 0));
    check_eq("pend_valid", pend_valid, m_pv);
    check_eq("pend_addr", pend_addr, m_pa);
    check_eq("pend_data", pend_data, m_pd);
    for (int i = 0; i < 32; i++) begin
      check_eq($sformatf("reg%0d", i), regs_flat[i*32 +: 32], m_regs[i]);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d, input logic c);
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    clear_req = c;
    @(posedge clock);
    model_edge(v, a, d, c);
    #1;
    check_all();
    if (busy) busy_cycles++;
    @(negedge clock);
  endtask

  logic        held;
  logic [4:0]  h_addr;
  logic [31:0] h_data;

  initial begin
    reset     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'd0;
    clear_req = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rel_ready", wr_ready, 1'b1);
    check_eq("rel_busy", busy, 1'b0);
    @(negedge clock);

    // Single write, then stream with same-address overwrite, then register 0 discard
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 5'd1, 32'h11, 1'b0);
    step(1'b1, 5'd2, 32'h22, 1'b0);
    step(1'b1, 5'd1, 32'h33, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);

    // Fill, clear, with a write held through the clear
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), $urandom | 32'h1, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    busy_cycles = 0;
    step(1'b0, 5'd0, 32'd0, 1'b1);
    held = 1'b1;
    for (int i = 0; i < 36; i++) begin
      logic acc;
      acc = (m_cnt == 0);
      step(held, 5'd9, 32'hABC, 1'b0);
      if (acc) held = 1'b0;
    end
    check_eq("busy_len", busy_cycles, 32);

    // Collision: write staged with clear, committed in drain, zeroed later; reset mid-clear
    step(1'b1, 5'd7, 32'h77, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 5'd0, 32'd0, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b0);

    // Random traffic with occasional clears
    held = 1'b0;
    for (int n = 0; n < 800; n++) begin
      logic acc;
      logic c;
      if (!held && ($urandom % 3 != 0)) begin
        held   = 1'b1;
        h_addr = 5'($urandom % 32);
        h_data = $urandom;
      end
      c   = ($urandom % 40 == 0);
      acc = (m_cnt == 0);
      step(held, h_addr, h_data, c);
      if (acc) held = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
